// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store front-end: funct3 encodings, FSM states
// and the store lane/mask helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } lsu_state_e;

    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = a[0];
            2'b10:   mis = (a != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] m;
        case (f3)
            F3_B:    m = 4'b0001 << a;
            F3_H:    m = a[1] ? 4'b1100 : 4'b0011;
            F3_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_replicate(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3)
            F3_B:    r = {4{d[7:0]}};
            F3_H:    r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_mem_if_load_align.sv
// Selects the addressed byte/halfword lanes of a RAM word and extends them to 32 bits.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [3:0][7:0] word,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [31:0]     ext
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select and sign/zero extension
    always_comb begin
        byte_s = word[addr_lo];
        if (addr_lo[1]) begin
            half_s = {word[3], word[2]};
        end else begin
            half_s = {word[1], word[0]};
        end
        case (funct3)
            F3_B:    ext = {{24{byte_s[7]}}, byte_s};
            F3_H:    ext = {{16{half_s[15]}}, half_s};
            F3_W:    ext = word;
            F3_BU:   ext = {24'h000000, byte_s};
            F3_HU:   ext = {16'h0000, half_s};
            default: ext = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// Single-outstanding load/store front-end driving one port of the byte-addressable
// data RAM and returning one completion per request to writeback.
module lsu_mem_if
    import lsu_pkg::*;
#(
    parameter int DEPTH  = 8192,
    parameter int ADDR_W = $clog2(DEPTH) + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              t_req_valid,
    output logic              t_req_ready,
    input  logic              t_req_we,
    input  logic [2:0]        t_req_funct3,
    input  logic [ADDR_W-1:0] t_req_addr,
    input  logic [31:0]       t_req_wdata,
    input  logic [4:0]        t_req_rd,
    output logic              i_mem_valid,
    input  logic              i_mem_ready,
    output logic              i_mem_we,
    output logic [ADDR_W-1:0] i_mem_addr,
    output logic [3:0][7:0]   i_mem_data,
    output logic [3:0]        i_mem_mask,
    input  logic              t_mem_valid,
    output logic              t_mem_ready,
    input  logic [3:0][7:0]   t_mem_data,
    output logic              i_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       i_rsp_data,
    output logic [4:0]        i_rsp_rd,
    output logic              i_rsp_is_load,
    output logic              i_rsp_err
);

    lsu_state_e        state_r;
    lsu_state_e        state_s;
    logic              req_ready_r;
    logic              mem_valid_r;
    logic              rsp_valid_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_data_r;
    logic [3:0]        mem_mask_r;
    logic [2:0]        f3_r;
    logic [1:0]        addr_lo_r;
    logic [31:0]       rsp_data_r;
    logic [4:0]        rsp_rd_r;
    logic              rsp_is_load_r;
    logic              rsp_err_r;
    logic              accept_s;
    logic              req_ok_s;
    logic              store_ok_s;
    logic [31:0]       load_ext_s;

    assign accept_s   = t_req_valid & req_ready_r;
    assign req_ok_s   = funct3_legal(t_req_we, t_req_funct3) & ~misaligned(t_req_funct3, t_req_addr[1:0]);
    assign store_ok_s = t_req_we & req_ok_s;

    lsu_load_align u_load_align (
        .word    (t_mem_data),
        .addr_lo (addr_lo_r),
        .funct3  (f3_r),
        .ext     (load_ext_s)
    );

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (req_ok_s) begin
                        state_s = ISSUE;
                    end else begin
                        state_s = RESP;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (i_mem_ready) begin
                    if (mem_we_r) begin
                        state_s = RESP;
                    end else begin
                        state_s = WAIT;
                    end
                end else begin
                    state_s = ISSUE;
                end
            end
            WAIT: begin
                if (t_mem_valid) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Handshake flags registered from the next state so they align with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready_r <= 1'b1;
            mem_valid_r <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            req_ready_r <= (state_s == IDLE);
            mem_valid_r <= (state_s == ISSUE);
            rsp_valid_r <= (state_s == RESP);
        end
    end

    // Request capture, RAM command and completion payload; errored requests never write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we_r      <= 1'b0;
            mem_addr_r    <= '0;
            mem_data_r    <= 32'h0000_0000;
            mem_mask_r    <= 4'b0000;
            f3_r          <= 3'b000;
            addr_lo_r     <= 2'b00;
            rsp_data_r    <= 32'h0000_0000;
            rsp_rd_r      <= 5'd0;
            rsp_is_load_r <= 1'b0;
            rsp_err_r     <= 1'b0;
        end else if (accept_s) begin
            mem_we_r      <= store_ok_s;
            mem_addr_r    <= {t_req_addr[ADDR_W-1:2], 2'b00};
            mem_data_r    <= t_req_we ? store_replicate(t_req_funct3, t_req_wdata) : 32'h0000_0000;
            mem_mask_r    <= store_ok_s ? store_mask(t_req_funct3, t_req_addr[1:0]) : 4'b0000;
            f3_r          <= t_req_funct3;
            addr_lo_r     <= t_req_addr[1:0];
            rsp_data_r    <= 32'h0000_0000;
            rsp_rd_r      <= t_req_rd;
            rsp_is_load_r <= ~t_req_we;
            rsp_err_r     <= ~req_ok_s;
        end else if ((state_r == WAIT) && t_mem_valid) begin
            rsp_data_r <= load_ext_s;
        end
    end

    assign t_req_ready   = req_ready_r;
    assign i_mem_valid   = mem_valid_r;
    assign i_mem_we      = mem_we_r;
    assign i_mem_addr    = mem_addr_r;
    assign i_mem_data    = mem_data_r;
    assign i_mem_mask    = mem_mask_r;
    assign t_mem_ready   = 1'b1;
    assign i_rsp_valid   = rsp_valid_r;
    assign i_rsp_data    = rsp_data_r;
    assign i_rsp_rd      = rsp_rd_r;
    assign i_rsp_is_load = rsp_is_load_r;
    assign i_rsp_err     = rsp_err_r;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if: a byte-level reference memory predicts every
// completion; a RAM responder and per-cycle compare process surround the DUT.
module tb_lsu_mem_if;

    localparam int ADDR_W = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              t_req_valid, t_req_ready, t_req_we;
    logic [2:0]        t_req_funct3;
    logic [ADDR_W-1:0] t_req_addr;
    logic [31:0]       t_req_wdata;
    logic [4:0]        t_req_rd;
    logic              i_mem_valid, i_mem_ready, i_mem_we;
    logic [ADDR_W-1:0] i_mem_addr;
    logic [3:0][7:0]   i_mem_data;
    logic [3:0]        i_mem_mask;
    logic              t_mem_valid, t_mem_ready;
    logic [3:0][7:0]   t_mem_data;
    logic              i_rsp_valid, i_rsp_ready;
    logic [31:0]       i_rsp_data;
    logic [4:0]        i_rsp_rd;
    logic              i_rsp_is_load, i_rsp_err;

    always #5 clk = ~clk;

    lsu_mem_if #(.DEPTH(8192)) dut (
        .clk(clk), .rst(rst),
        .t_req_valid(t_req_valid), .t_req_ready(t_req_ready), .t_req_we(t_req_we),
        .t_req_funct3(t_req_funct3), .t_req_addr(t_req_addr), .t_req_wdata(t_req_wdata),
        .t_req_rd(t_req_rd),
        .i_mem_valid(i_mem_valid), .i_mem_ready(i_mem_ready), .i_mem_we(i_mem_we),
        .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data), .i_mem_mask(i_mem_mask),
        .t_mem_valid(t_mem_valid), .t_mem_ready(t_mem_ready), .t_mem_data(t_mem_data),
        .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data),
        .i_rsp_rd(i_rsp_rd), .i_rsp_is_load(i_rsp_is_load), .i_rsp_err(i_rsp_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte memory plus the expected outcome of the current request
    logic [7:0]        ref_mem [int];
    logic [31:0]       ram     [int];
    logic              exp_err, exp_is_load, exp_mwe;
    logic [4:0]        exp_rd;
    logic [ADDR_W-1:0] exp_maddr;
    logic [3:0]        exp_mask;
    logic [31:0]       exp_mdata, exp_rdata;

    function automatic logic [7:0] ref_byte(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    task automatic model_req(input logic we, input logic [2:0] f3, input logic [ADDR_W-1:0] addr,
                             input logic [31:0] wdata, input logic [4:0] rd);
        int a, sz, off;
        logic legal;
        logic [31:0] v;
        a     = int'(addr);
        legal = we ? (f3 inside {3'b000, 3'b001, 3'b010})
                   : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        sz    = 1 << f3[1:0];
        exp_err     = !legal || ((a % sz) != 0);
        exp_is_load = !we;
        exp_rd      = rd;
        exp_mwe     = we && !exp_err;
        exp_maddr   = {addr[ADDR_W-1:2], 2'b00};
        exp_mask    = 4'b0000;
        exp_mdata   = 32'h0;
        exp_rdata   = 32'h0;
        if (!exp_err) begin
            off = a % 4;
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (i >= off && i < off + sz) exp_mask[i] = 1'b1;
                    exp_mdata[8*i +: 8] = wdata[8*(i % sz) +: 8];
                end
                for (int k = 0; k < sz; k++) ref_mem[a + k] = wdata[8*k +: 8];
            end else begin
                v = 32'h0;
                for (int k = 0; k < sz; k++) v = v | (32'(ref_byte(a + k)) << (8 * k));
                if (sz < 4 && !f3[2] && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
                exp_rdata = v;
            end
        end
    endtask

    // Environment/compare state
    bit          txn_active = 1'b0;
    bit          mem_done;
    bit          rd_pend = 1'b0;
    int          cyc, rsp_first;
    int          mem_stall = 0, rsp_stall = 0, rd_delay = 0, rd_cnt = 0;
    logic [31:0] rd_word;
    logic [3:0]  cap_mask;
    logic [31:0] cap_mdata, cap_rdata;
    logic [ADDR_W-1:0] cap_maddr;
    logic        cap_err;

    // RAM responder, ready generation and per-cycle comparison against the model
    always @(negedge clk) begin
        t_mem_valid = 1'b0;
        if (rd_pend) begin
            if (rd_cnt > 0) begin
                rd_cnt--;
            end else begin
                t_mem_valid = 1'b1;
                t_mem_data  = rd_word;
                rd_pend     = 1'b0;
            end
        end
        i_mem_ready = i_mem_valid && (mem_stall == 0);
        if (i_mem_valid && mem_stall > 0) mem_stall--;
        i_rsp_ready = i_rsp_valid && (rsp_stall == 0);
        if (i_rsp_valid && rsp_stall > 0) rsp_stall--;

        if (txn_active) begin
            cyc++;
            check("req_ready_busy", t_req_ready, 1'b0);
            if (i_mem_valid) begin
                check("mem_req_allowed", exp_err || mem_done, 1'b0);
                check("mem_we", i_mem_we, exp_mwe);
                check("mem_addr", i_mem_addr, exp_maddr);
                check("mem_mask", i_mem_mask, exp_mask);
                if (exp_mwe) check("mem_data", i_mem_data, exp_mdata);
                if (i_mem_ready && !mem_done) begin
                    mem_done  = 1'b1;
                    cap_mask  = i_mem_mask;
                    cap_mdata = i_mem_data;
                    cap_maddr = i_mem_addr;
                    if (i_mem_we) begin
                        if (!ram.exists(int'(i_mem_addr[ADDR_W-1:2]))) ram[int'(i_mem_addr[ADDR_W-1:2])] = 32'h0;
                        for (int i = 0; i < 4; i++)
                            if (i_mem_mask[i]) ram[int'(i_mem_addr[ADDR_W-1:2])][8*i +: 8] = i_mem_data[i];
                    end else begin
                        rd_word = ram.exists(int'(i_mem_addr[ADDR_W-1:2])) ? ram[int'(i_mem_addr[ADDR_W-1:2])] : 32'h0;
                        rd_pend = 1'b1;
                        rd_cnt  = rd_delay;
                    end
                end
            end
            if (i_rsp_valid) begin
                check("rsp_data", i_rsp_data, exp_rdata);
                check("rsp_rd", i_rsp_rd, exp_rd);
                check("rsp_is_load", i_rsp_is_load, exp_is_load);
                check("rsp_err", i_rsp_err, exp_err);
                if (rsp_first < 0) rsp_first = cyc;
                if (i_rsp_ready) begin
                    cap_rdata  = i_rsp_data;
                    cap_err    = i_rsp_err;
                    txn_active = 1'b0;
                end
            end
        end else begin
            check("idle_mem_valid", i_mem_valid, 1'b0);
            check("idle_rsp_valid", i_rsp_valid, 1'b0);
        end
    end

    task automatic start_req(input logic we, input logic [2:0] f3, input logic [ADDR_W-1:0] addr,
                             input logic [31:0] wdata, input logic [4:0] rd, input int mstall, input int rstall);
        model_req(we, f3, addr, wdata, rd);
        mem_stall = mstall;
        rsp_stall = rstall;
        @(negedge clk);
        t_req_valid  = 1'b1;
        t_req_we     = we;
        t_req_funct3 = f3;
        t_req_addr   = addr;
        t_req_wdata  = wdata;
        t_req_rd     = rd;
        check("req_ready_idle", t_req_ready, 1'b1);
        @(posedge clk);
        cyc        = 0;
        rsp_first  = -1;
        mem_done   = 1'b0;
        cap_rdata  = 32'hXXXX_XXXX;
        cap_err    = 1'bx;
        txn_active = 1'b1;
        @(negedge clk);
        t_req_valid = 1'b0;
    endtask

    task automatic run_req(input logic we, input logic [2:0] f3, input logic [ADDR_W-1:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd, input int mstall, input int rstall,
                           input int lat, input logic [31:0] lit_data, input logic lit_err);
        start_req(we, f3, addr, wdata, rd, mstall, rstall);
        for (int i = 0; i < 40 && txn_active; i++) @(negedge clk);
        check("rsp_timeout", txn_active, 1'b0);
        txn_active = 1'b0;
        check("rsp_latency", rsp_first, lat);
        check("lit_rsp_data", cap_rdata, lit_data);
        check("lit_rsp_err", cap_err, lit_err);
        check("mem_access_made", mem_done, !lit_err);
    endtask

    initial begin
        rst = 1'b1;
        t_req_valid = 1'b0; t_req_we = 1'b0; t_req_funct3 = 3'b000;
        t_req_addr = '0; t_req_wdata = 32'h0; t_req_rd = 5'd0;
        i_mem_ready = 1'b0; i_rsp_ready = 1'b0; t_mem_valid = 1'b0; t_mem_data = 32'h0;
        @(negedge clk);
        check("rst_req_ready", t_req_ready, 1'b1);
        check("rst_mem_we", i_mem_we, 1'b0);
        check("rst_mem_mask", i_mem_mask, 4'b0000);
        check("rst_rsp_data", i_rsp_data, 32'h0);
        check("rst_rsp_err", i_rsp_err, 1'b0);
        check("mem_ready_tie", t_mem_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Word store then loads of every width from the same word
        run_req(1'b1, 3'b010, 15'h0100, 32'hDEADBEEF, 5'd1, 0, 0, 2, 32'h0, 1'b0);
        check("sw_mask", cap_mask, 4'b1111);
        check("sw_addr", cap_maddr, 15'h0100);
        run_req(1'b0, 3'b010, 15'h0100, 32'h0, 5'd2, 0, 0, 3, 32'hDEADBEEF, 1'b0);
        run_req(1'b0, 3'b000, 15'h0101, 32'h0, 5'd3, 0, 0, 3, 32'hFFFFFFBE, 1'b0);
        run_req(1'b0, 3'b101, 15'h0102, 32'h0, 5'd4, 0, 0, 3, 32'h0000DEAD, 1'b0);

        // Byte store into lane 3, then signed and unsigned byte loads
        run_req(1'b1, 3'b000, 15'h0103, 32'h000000A5, 5'd5, 0, 0, 2, 32'h0, 1'b0);
        check("sb_mask", cap_mask, 4'b1000);
        check("sb_data", cap_mdata, 32'hA5A5A5A5);
        run_req(1'b0, 3'b000, 15'h0103, 32'h0, 5'd6, 0, 0, 3, 32'hFFFFFFA5, 1'b0);
        run_req(1'b0, 3'b100, 15'h0103, 32'h0, 5'd7, 0, 0, 3, 32'h000000A5, 1'b0);

        // Upper halfword store, then signed and unsigned halfword loads
        run_req(1'b1, 3'b001, 15'h0202, 32'h00008001, 5'd8, 0, 0, 2, 32'h0, 1'b0);
        check("sh_mask", cap_mask, 4'b1100);
        check("sh_data", cap_mdata, 32'h80018001);
        run_req(1'b0, 3'b001, 15'h0202, 32'h0, 5'd9, 0, 0, 3, 32'hFFFF8001, 1'b0);
        run_req(1'b0, 3'b101, 15'h0202, 32'h0, 5'd10, 0, 0, 3, 32'h00008001, 1'b0);

        // Misaligned and illegal requests complete in cycle 1 with no RAM access
        run_req(1'b0, 3'b010, 15'h0101, 32'h0, 5'd11, 0, 0, 1, 32'h0, 1'b1);
        run_req(1'b0, 3'b001, 15'h0203, 32'h0, 5'd12, 0, 0, 1, 32'h0, 1'b1);
        run_req(1'b0, 3'b011, 15'h0100, 32'h0, 5'd13, 0, 0, 1, 32'h0, 1'b1);
        run_req(1'b1, 3'b100, 15'h0100, 32'h12345678, 5'd14, 0, 0, 1, 32'h0, 1'b1);

        // Back-pressure on both the RAM port and the completion channel
        run_req(1'b1, 3'b010, 15'h0300, 32'h12345678, 5'd15, 3, 2, 5, 32'h0, 1'b0);
        run_req(1'b0, 3'b010, 15'h0300, 32'h0, 5'd16, 3, 2, 6, 32'h12345678, 1'b0);

        // Reset in WAIT: the late read data must be dropped
        rd_delay = 1;
        start_req(1'b0, 3'b010, 15'h0100, 32'h0, 5'd17, 0, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        txn_active = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        rd_delay = 0;
        repeat (3) @(negedge clk);
        check("post_rst_req_ready", t_req_ready, 1'b1);
        check("post_rst_mem_seen", mem_done, 1'b1);
        run_req(1'b0, 3'b010, 15'h0100, 32'h0, 5'd18, 0, 0, 3, 32'hA5ADBEEF, 1'b0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
